// File: rtl/upsample2x_unpool.sv
`default_nettype none
// ============================================================================
// Module   : upsample2x_unpool
// Brief    : Nearest-neighbour 2x2 upsampler; repeats each pixel and replays
//            each row from an internal row buffer.
// Revision : 1.0
// ============================================================================
module upsample2x_unpool #(
   parameter int DATA_W = 8,
   parameter int IN_W   = 16,
   parameter int IN_H   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic [DATA_W-1:0] din,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [DATA_W-1:0] dout,
   output logic              dout_eol,
   output logic              dout_eof
);

   localparam int c_COL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int c_ROW_W = (IN_H > 1) ? $clog2(IN_H) : 1;
   localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IN_W - 1);
   localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IN_H - 1);

   typedef enum logic [0:0] {
      S_FIRST  = 1'b0,
      S_REPLAY = 1'b1
   } state_t;

   state_t              r_st;
   logic [c_COL_W-1:0]  r_col;
   logic                r_phase;
   logic [c_ROW_W-1:0]  r_row;
   logic [DATA_W-1:0]   r_hold_data;
   logic                r_hold_valid;
   logic [DATA_W-1:0]   r_rowbuf [IN_W];

   logic                w_col_last;
   logic                w_row_end;
   logic                w_in_xfer;
   logic                w_out_xfer;
   logic [c_COL_W-1:0]  w_wr_col;

   assign w_col_last = (r_col == c_COL_LAST);
   assign w_row_end  = r_phase && w_col_last;

   // The last pixel of a row blocks input: the next pixel starts a new input row.
   assign din_ready  = (r_st == S_FIRST) &&
                       (!r_hold_valid || (r_phase && dout_ready && !w_col_last));
   assign dout_valid = (r_st == S_REPLAY) || r_hold_valid;
   assign dout       = (r_st == S_REPLAY) ? r_rowbuf[r_col] : r_hold_data;
   assign dout_eol   = dout_valid && w_row_end;
   assign dout_eof   = dout_eol && (r_st == S_REPLAY) && (r_row == c_ROW_LAST);

   assign w_in_xfer  = din_valid && din_ready;
   assign w_out_xfer = dout_valid && dout_ready;

   // A pixel accepted while the hold is still busy belongs to the next column.
   assign w_wr_col   = r_hold_valid ? (r_col + 1'b1) : r_col;

   always_ff @(posedge clk) begin
      if (w_in_xfer) begin
         r_rowbuf[w_wr_col] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st         <= S_FIRST;
         r_col        <= '0;
         r_phase      <= 1'b0;
         r_row        <= '0;
         r_hold_data  <= '0;
         r_hold_valid <= 1'b0;
      end else begin
         if (w_out_xfer) begin
            if (!r_phase) begin
               r_phase <= 1'b1;
            end else begin
               r_phase      <= 1'b0;
               r_hold_valid <= 1'b0;
               if (w_col_last) begin
                  r_col <= '0;
                  if (r_st == S_FIRST) begin
                     r_st <= S_REPLAY;
                  end else begin
                     r_st  <= S_FIRST;
                     r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
                  end
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
         end
         // A simultaneous input overrides the hold release, so no bubble appears.
         if (w_in_xfer) begin
            r_hold_data  <= din;
            r_hold_valid <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/upsample2x_unpool.md
Name: upsample2x_unpool

Overview:
- Nearest-neighbour 2x2 upsampler for 8-bit pixel streams; the inverse direction of the 2x2 max-pool stage.
- Accepts a pooled feature map of IN_W x IN_H pixels, raster order, one pixel per handshake.
- Emits a 2*IN_W x 2*IN_H map: each pixel is repeated horizontally, and each row is replayed once from an internal row buffer.
- Sits on the decoder/expansion side of the CNN datapath and feeds the next convolution or line-buffer stage.

Parameters:
DATA_W, 8, pixel width in bits
IN_W, 16, input pixels per row (power of 2 not required, >=2)
IN_H, 16, input rows per frame (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
din_valid  input  1  input pixel valid
din_ready  output  1  block can accept input pixel this cycle
din  input  DATA_W  input pixel, raster order
dout_valid  output  1  output pixel valid
dout_ready  input  1  downstream accepts output pixel this cycle
dout  output  DATA_W  output pixel
dout_eol  output  1  high with last pixel of each output row
dout_eof  output  1  high with last pixel of the frame

Behaviour:
- Handshakes: input transfer when din_valid && din_ready; output transfer when dout_valid && dout_ready.
- While dout_valid is high and dout_ready is low, dout, dout_eol and dout_eof hold stable.
- State: st ∈ {S_FIRST, S_REPLAY}.
- Counters: col (0..IN_W-1), phase (0/1 horizontal copy), row (0..IN_H-1).
- Hold register: hold_data plus hold_valid.
- Row buffer: rowbuf[0..IN_W-1] of DATA_W bits.
- Reset (async): st=S_FIRST; col=0, phase=0, row=0; hold_valid=0, hold_data=0; rowbuf contents don't-care.
- Outputs during and after reset: dout_valid=0, dout=0, dout_eol=0, dout_eof=0, din_ready=1 (combinational, empty hold).
- S_FIRST, input side:
  - din_ready = !hold_valid || (phase==1 && dout_ready).
  - On an input transfer: hold_data<=din, hold_valid<=1, rowbuf[col]<=din.
- S_FIRST, output side:
  - dout_valid = hold_valid; dout = hold_data.
  - Latency: a pixel accepted at edge N is first presented in the cycle after edge N.
- S_FIRST, advancing on each output transfer:
  - phase 0 -> 1.
  - phase 1 -> 0, col+1. If no new input arrives in the same cycle, hold_valid<=0.
  - Simultaneous phase-1 output transfer and input transfer: the new pixel loads directly (hold_valid stays 1), giving no bubble.
- S_FIRST, row end: on the output transfer with col==IN_W-1 and phase==1, set col<=0 and st<=S_REPLAY.
  - din_ready=0 at that point, because the next pixel belongs to the next input row.
- S_REPLAY:
  - din_ready=0; dout_valid=1; dout=rowbuf[col].
  - Advance phase/col on each output transfer, as in S_FIRST.
  - On the transfer with col==IN_W-1 and phase==1: col<=0, st<=S_FIRST, hold_valid<=0.
  - At that same transfer, row<=row+1, or row<=0 when row==IN_H-1.
- Flags:
  - dout_eol = dout_valid && col==IN_W-1 && phase==1, in either state.
  - dout_eof = dout_eol && st==S_REPLAY && row==IN_H-1.
- Throughput:
  - First copy of each row: 1 input pixel per 2 cycles, 1 output per cycle with dout_ready held high.
  - Replay row: 2*IN_W cycles with input stalled.
- Frames run back to back with no idle cycles required; no frame start signal, the row counter defines position.
- Input gaps (din_valid low) create output bubbles in S_FIRST only; they never occur in S_REPLAY.
- Reset asserted mid-operation: immediately returns to the reset state and drops any partial row or frame. The first pixel after reset release is treated as pixel (0,0).

Test Plan:
- Reset: hold rst_n=0 with din_valid=1 -> dout_valid=0, dout=0, dout_eol=0, din_ready=1; no transfer is counted after release until the first clk edge.
- Basic, with IN_W=4, IN_H=2, dout_ready=1: feed 1,2,3,4 -> dout 1,1,2,2,3,3,4,4 then 1,1,2,2,3,3,4,4.
  - dout_eol on outputs 8 and 16; dout_eof=0.
  - din_ready=0 for all 8 replay cycles.
- Full frame, same params: feed rows 1..4 then 5..8 -> 32 outputs; second output pair is 5,5,...,8,8 twice.
  - dout_eof only on output 32; row wraps to 0.
  - Next pixel 9 appears twice as the first output of the next frame.
- Backpressure: drop dout_ready for 3 cycles while dout=2 (phase 0) -> dout stays 2 with dout_valid=1 and din_ready=0; then resumes 2,3,3.
- Input gaps: din_valid toggled 1,0,0,1 -> dout_valid low during the gap cycles; no duplicate or lost pixels; replay row still contiguous.
- Reset mid-replay: assert rst_n=0 at replay col=2 -> outputs clear; after release, feeding 7,8,9,10 yields 7,7,8,8,... as a fresh row 0.
